stage1_fetch: RTL and testbench

STAGE1_FETCH -- requirements
Module: stage1_fetch

---
 rtl/stage1_fetch.sv | 90 +++++++++
 tb/tb_stage1_fetch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stage1_fetch.sv
// rtl/stage1_fetch.sv - instruction fetch stage with one-outstanding icache request and IF/ID register
module stage1_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        pc_sel,
    input  logic        stall_in,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic [31:0] icache_dout,
    input  logic        icache_valid,
    output logic        fetch_stall,
    output logic [31:0] inst_out,
    output logic [31:0] pc_id,
    output logic        valid_id
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HELD = 2'd2,
        S_KILL = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] inst_buf;

    assign icache_addr = pc_in;
    assign icache_re   = reset && (state == S_REQ) && !stall_in && !pc_sel;

    // PC may advance only when a redirect is taken or an instruction enters IF/ID this edge
    assign fetch_stall = !(pc_sel
                        || ((state == S_WAIT) && icache_valid && !stall_in)
                        || ((state == S_HELD) && !stall_in));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_REQ;
            inst_out <= NOP_INST;
            pc_id    <= 32'h0;
            valid_id <= 1'b0;
            inst_buf <= 32'h0;
        end else if (pc_sel) begin
            // Redirect squashes IF/ID; an unanswered request must still be drained
            valid_id <= 1'b0;
            inst_out <= NOP_INST;
            inst_buf <= 32'h0;
            if (((state == S_WAIT) || (state == S_KILL)) && !icache_valid)
                state <= S_KILL;
            else
                state <= S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (!stall_in)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (icache_valid) begin
                        if (stall_in) begin
                            inst_buf <= icache_dout;
                            state    <= S_HELD;
                        end else begin
                            inst_out <= icache_dout;
                            pc_id    <= pc_in;
                            valid_id <= 1'b1;
                            state    <= S_REQ;
                        end
                    end
                end
                S_HELD: begin
                    if (!stall_in) begin
                        inst_out <= inst_buf;
                        pc_id    <= pc_in;
                        valid_id <= 1'b1;
                        state    <= S_REQ;
                    end
                end
                S_KILL: begin
                    if (icache_valid)
                        state <= S_REQ;
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage1_fetch.sv
// tb/tb_stage1_fetch.sv - vector table, corner sequences and random run against a transaction model
module tb_stage1_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        pc_sel = 1'b0;
    logic        stall_in = 1'b0;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout = 32'h0;
    logic        icache_valid = 1'b0;
    logic        fetch_stall;
    logic [31:0] inst_out;
    logic [31:0] pc_id;
    logic        valid_id;

    stage1_fetch #(.NOP_INST(NOP)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_sel(pc_sel), .stall_in(stall_in),
        .icache_addr(icache_addr), .icache_re(icache_re), .icache_dout(icache_dout),
        .icache_valid(icache_valid), .fetch_stall(fetch_stall), .inst_out(inst_out),
        .pc_id(pc_id), .valid_id(valid_id)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic re, input logic fs,
                             input logic [31:0] inst, input logic [31:0] pcid, input logic vld);
        check({tag, ".addr"}, icache_addr, pc_in);
        check({tag, ".re"}, {31'b0, icache_re}, {31'b0, re});
        check({tag, ".fetch_stall"}, {31'b0, fetch_stall}, {31'b0, fs});
        check({tag, ".inst_out"}, inst_out, inst);
        check({tag, ".pc_id"}, pc_id, pcid);
        check({tag, ".valid_id"}, {31'b0, valid_id}, {31'b0, vld});
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        stall, sel, v;
        logic [31:0] dout;
        logic        re, fs;
        logic [31:0] inst, pcid;
        logic        vld;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic stall, logic sel, logic v, logic [31:0] dout,
                                logic re, logic fs, logic [31:0] inst, logic [31:0] pcid, logic vld);
        vec_t r;
        r.pc = pc; r.stall = stall; r.sel = sel; r.v = v; r.dout = dout;
        r.re = re; r.fs = fs; r.inst = inst; r.pcid = pcid; r.vld = vld;
        return r;
    endfunction

    vec_t tbl[23];

    // Transaction-level reference: request in flight, doomed flag, buffered response
    logic [31:0] m_inst, m_pc, m_bufd;
    logic        m_vld, m_out, m_disc, m_buf;
    logic        c_pend;
    int          c_cnt;

    task automatic model_reset();
        m_inst = NOP; m_pc = 32'h0; m_vld = 1'b0; m_bufd = 32'h0;
        m_out = 1'b0; m_disc = 1'b0; m_buf = 1'b0; c_pend = 1'b0; c_cnt = 0;
    endtask

    task automatic model_step(output logic exp_re, output logic exp_fs);
        logic idle, delivered;
        idle = !m_out && !m_buf;
        exp_re = idle && !stall_in && !pc_sel;
        exp_fs = !(pc_sel || (m_out && !m_disc && icache_valid && !stall_in) || (m_buf && !stall_in));
        delivered = icache_valid;
        if (pc_sel) begin
            m_vld = 1'b0; m_inst = NOP; m_buf = 1'b0;
            m_out = m_out && !icache_valid;
            m_disc = m_out;
        end else if (m_out && icache_valid) begin
            m_out = 1'b0;
            if (m_disc) m_disc = 1'b0;
            else if (stall_in) begin m_buf = 1'b1; m_bufd = icache_dout; end
            else begin m_inst = icache_dout; m_pc = pc_in; m_vld = 1'b1; end
        end else if (m_buf && !stall_in) begin
            m_inst = m_bufd; m_pc = pc_in; m_vld = 1'b1; m_buf = 1'b0;
        end else if (exp_re) begin
            m_out = 1'b1; m_disc = 1'b0;
        end
        if (delivered) c_pend = 1'b0;
        else if (c_pend) c_cnt--;
        if (exp_re) begin c_pend = 1'b1; c_cnt = int'($urandom_range(1, 3)); end
    endtask

    initial begin
        logic er, ef;
        tbl[0]  = mk(32'h2000, 0, 0, 0, 32'h0,        1, 1, NOP,          32'h0,    0);
        tbl[1]  = mk(32'h2000, 0, 0, 1, 32'h00500093, 0, 0, NOP,          32'h0,    0);
        tbl[2]  = mk(32'h2004, 0, 0, 0, 32'h0,        1, 1, 32'h00500093, 32'h2000, 1);
        tbl[3]  = mk(32'h2004, 0, 0, 0, 32'h0,        0, 1, 32'h00500093, 32'h2000, 1);
        tbl[4]  = mk(32'h2004, 0, 0, 0, 32'h0,        0, 1, 32'h00500093, 32'h2000, 1);
        tbl[5]  = mk(32'h2004, 0, 0, 0, 32'h0,        0, 1, 32'h00500093, 32'h2000, 1);
        tbl[6]  = mk(32'h2004, 0, 0, 1, 32'h00A00113, 0, 0, 32'h00500093, 32'h2000, 1);
        tbl[7]  = mk(32'h2008, 0, 0, 0, 32'h0,        1, 1, 32'h00A00113, 32'h2004, 1);
        tbl[8]  = mk(32'h2008, 1, 0, 1, 32'h00F00193, 0, 1, 32'h00A00113, 32'h2004, 1);
        tbl[9]  = mk(32'h2008, 1, 0, 0, 32'h0,        0, 1, 32'h00A00113, 32'h2004, 1);
        tbl[10] = mk(32'h2008, 0, 0, 0, 32'h0,        0, 0, 32'h00A00113, 32'h2004, 1);
        tbl[11] = mk(32'h200C, 0, 0, 0, 32'h0,        1, 1, 32'h00F00193, 32'h2008, 1);
        tbl[12] = mk(32'h200C, 0, 0, 0, 32'h0,        0, 1, 32'h00F00193, 32'h2008, 1);
        tbl[13] = mk(32'h200C, 0, 1, 0, 32'h0,        0, 0, 32'h00F00193, 32'h2008, 1);
        tbl[14] = mk(32'h3000, 0, 0, 0, 32'h0,        0, 1, NOP,          32'h2008, 0);
        tbl[15] = mk(32'h3000, 0, 0, 1, 32'hDEADBEEF, 0, 1, NOP,          32'h2008, 0);
        tbl[16] = mk(32'h3000, 0, 0, 0, 32'h0,        1, 1, NOP,          32'h2008, 0);
        tbl[17] = mk(32'h3000, 1, 0, 1, 32'h00100073, 0, 1, NOP,          32'h2008, 0);
        tbl[18] = mk(32'h3000, 1, 1, 0, 32'h0,        0, 0, NOP,          32'h2008, 0);
        tbl[19] = mk(32'h3004, 0, 0, 1, 32'h0BAD0BAD, 1, 1, NOP,          32'h2008, 0);
        tbl[20] = mk(32'h3004, 0, 0, 0, 32'h0,        0, 1, NOP,          32'h2008, 0);
        tbl[21] = mk(32'h3004, 0, 0, 1, 32'h11111111, 0, 0, NOP,          32'h2008, 0);
        tbl[22] = mk(32'h3008, 0, 0, 0, 32'h0,        1, 1, 32'h11111111, 32'h3004, 1);

        repeat (2) @(negedge clk);
        check_out("reset", 1'b0, 1'b1, NOP, 32'h0, 1'b0);

        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 23; i++) begin
            if (i > 0) @(negedge clk);
            pc_in = tbl[i].pc; stall_in = tbl[i].stall; pc_sel = tbl[i].sel;
            icache_valid = tbl[i].v; icache_dout = tbl[i].dout;
            #1;
            check_out($sformatf("row%0d", i), tbl[i].re, tbl[i].fs, tbl[i].inst, tbl[i].pcid, tbl[i].vld);
        end

        // Asynchronous reset in WAIT, between clock edges
        @(negedge clk);
        pc_in = 32'h3008; stall_in = 1'b0; pc_sel = 1'b0; icache_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_out("async_rst", 1'b0, 1'b1, NOP, 32'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1; pc_in = 32'h4000;
        #1 check_out("post_rst_req", 1'b1, 1'b1, NOP, 32'h0, 1'b0);
        @(negedge clk);
        icache_valid = 1'b1; icache_dout = 32'h00208233;
        #1 check_out("post_rst_rsp", 1'b0, 1'b0, NOP, 32'h0, 1'b0);
        @(negedge clk);
        icache_valid = 1'b0; pc_in = 32'h4004;
        #1 check_out("post_rst_load", 1'b1, 1'b1, 32'h00208233, 32'h4000, 1'b1);

        // Randomized run against the reference model
        @(negedge clk);
        reset = 1'b0; pc_sel = 1'b0; stall_in = 1'b0; icache_valid = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            reset = 1'b1;
            pc_in = $urandom & 32'hFFFF_FFFC;
            pc_sel = ($urandom_range(0, 7) == 0);
            stall_in = ($urandom_range(0, 2) == 0);
            icache_valid = c_pend && (c_cnt == 1);
            icache_dout = $urandom;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                #1 check_out("rand_rst", 1'b0, 1'b1, NOP, 32'h0, 1'b0);
                model_reset();
            end else begin
                #1;
                model_step(er, ef);
                check_out($sformatf("rand%0d", cyc), er, ef, m_inst_prev, m_pc_prev, m_vld_prev);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // IF/ID values before the coming edge, captured before the model advances
    logic [31:0] m_inst_prev, m_pc_prev;
    logic        m_vld_prev;
    always @(negedge clk) begin
        m_inst_prev <= m_inst;
        m_pc_prev   <= m_pc;
        m_vld_prev  <= m_vld;
    end

endmodule
